// File: rtl/line_window_scanner.sv
// Slides a 6-cell window across one packed board line, one window per clock, and reports
// the best unblocked window (most own stones, no opponent stone) plus the count of threat windows.

module adder_6_bits (
  input  logic [5:0] bits_i,
  output logic [2:0] sum_o
);
  always_comb begin
    sum_o = 3'd0;
    for (int i = 0; i < 6; i++) begin
      sum_o = sum_o + {2'b00, bits_i[i]};
    end
  end
endmodule

module line_window_scanner #(
  parameter int LINE_LEN = 19,
  parameter int POS_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LINE_LEN-1:0] line_own,
  input  logic [LINE_LEN-1:0] line_opp,
  output logic                busy,
  output logic                done,
  output logic                best_found,
  output logic [2:0]          best_count,
  output logic [POS_W-1:0]    best_pos,
  output logic [POS_W-1:0]    threat_cnt
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SCAN = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(LINE_LEN - 6);

  logic [1:0]          state_q, state_d;
  logic [LINE_LEN-1:0] own_q, own_d;
  logic [LINE_LEN-1:0] opp_q, opp_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                w_found_q, w_found_d;
  logic [2:0]          w_count_q, w_count_d;
  logic [POS_W-1:0]    w_pos_q, w_pos_d;
  logic [POS_W-1:0]    w_thr_q, w_thr_d;
  logic                best_found_q, best_found_d;
  logic [2:0]          best_count_q, best_count_d;
  logic [POS_W-1:0]    best_pos_q, best_pos_d;
  logic [POS_W-1:0]    threat_cnt_q, threat_cnt_d;

  logic [2:0] cnt;
  logic       blk;

  // The captured line shifts right one cell per scan cycle, so the current window is always [5:0].
  adder_6_bits u_adder (
    .bits_i (own_q[5:0]),
    .sum_o  (cnt)
  );

  assign blk = |opp_q[5:0];

  always_comb begin
    // NOTE: every next-state signal takes its current value first so no path leaves it unassigned
    // (which would infer a latch).
    state_d      = state_q;
    own_d        = own_q;
    opp_d        = opp_q;
    pos_d        = pos_q;
    w_found_d    = w_found_q;
    w_count_d    = w_count_q;
    w_pos_d      = w_pos_q;
    w_thr_d      = w_thr_q;
    best_found_d = best_found_q;
    best_count_d = best_count_q;
    best_pos_d   = best_pos_q;
    threat_cnt_d = threat_cnt_q;

    case (state_q)
      SCAN: begin
        own_d = own_q >> 1;
        opp_d = opp_q >> 1;
        // Strict compare keeps the lowest start cell on ties.
        if (!blk && (!w_found_q || cnt > w_count_q)) begin
          w_found_d = 1'b1;
          w_count_d = cnt;
          w_pos_d   = pos_q;
        end
        if (!blk && cnt >= 3'd4) begin
          w_thr_d = w_thr_q + POS_W'(1);
        end
        if (pos_q == LAST_POS) begin
          // Results are published on entry to DONE so they are valid in the done cycle itself.
          state_d      = DONE;
          best_found_d = w_found_d;
          best_count_d = w_count_d;
          best_pos_d   = w_pos_d;
          threat_cnt_d = w_thr_d;
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        if (start) begin
          own_d     = line_own & ~line_opp;
          opp_d     = line_opp;
          pos_d     = '0;
          w_found_d = 1'b0;
          w_count_d = 3'd0;
          w_pos_d   = '0;
          w_thr_d   = '0;
          state_d   = SCAN;
        end
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      w_found_q    <= 1'b0;
      w_count_q    <= 3'd0;
      w_pos_q      <= '0;
      w_thr_q      <= '0;
      best_found_q <= 1'b0;
      best_count_q <= 3'd0;
      best_pos_q   <= '0;
      threat_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      w_found_q    <= w_found_d;
      w_count_q    <= w_count_d;
      w_pos_q      <= w_pos_d;
      w_thr_q      <= w_thr_d;
      best_found_q <= best_found_d;
      best_count_q <= best_count_d;
      best_pos_q   <= best_pos_d;
      threat_cnt_q <= threat_cnt_d;
    end
  end

  // NOTE: the line registers carry no reset; they are always reloaded at capture before being read.
  always_ff @(posedge clk) begin
    own_q <= own_d;
    opp_q <= opp_d;
  end

  assign busy       = (state_q == SCAN) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign best_found = best_found_q;
  assign best_count = best_count_q;
  assign best_pos   = best_pos_q;
  assign threat_cnt = threat_cnt_q;

endmodule

// File: tb/tb_line_window_scanner.sv
// Self-checking bench for line_window_scanner: a per-line window model plus a cycle compare
// process, driven by directed scans with hand-computed expected results.

module tb_line_window_scanner;

  localparam int LINE_LEN = 19;
  localparam int POS_W    = 5;
  localparam int LATENCY  = LINE_LEN - 4;

  logic                clk;
  logic                rst;
  logic                start;
  logic [LINE_LEN-1:0] line_own;
  logic [LINE_LEN-1:0] line_opp;
  logic                busy;
  logic                done;
  logic                best_found;
  logic [2:0]          best_count;
  logic [POS_W-1:0]    best_pos;
  logic [POS_W-1:0]    threat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  line_window_scanner #(.LINE_LEN(LINE_LEN), .POS_W(POS_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .line_own   (line_own),
    .line_opp   (line_opp),
    .busy       (busy),
    .done       (done),
    .best_found (best_found),
    .best_count (best_count),
    .best_pos   (best_pos),
    .threat_cnt (threat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    bit found;
    int count;
    int pos;
    int thr;
  } res_t;

  // Evaluates every window of the line directly; a cell set in both inputs is an opponent cell.
  function automatic res_t model_scan(input logic [LINE_LEN-1:0] own, input logic [LINE_LEN-1:0] opp);
    res_t r;
    r.found = 0; r.count = 0; r.pos = 0; r.thr = 0;
    for (int w = 0; w <= LINE_LEN - 6; w++) begin
      int  c;
      bit  b;
      c = 0; b = 0;
      for (int j = 0; j < 6; j++) begin
        if (opp[w+j])      b = 1;
        else if (own[w+j]) c++;
      end
      if (!b) begin
        if (!r.found || c > r.count) begin
          r.found = 1; r.count = c; r.pos = w;
        end
        if (c >= 4) r.thr++;
      end
    end
    return r;
  endfunction

  // Model: cycles remaining until idle after an accepted start; results appear in the done cycle.
  bit   m_valid = 0;
  int   m_rem   = 0;
  res_t m_pend;
  res_t m_out;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1;
      m_rem   <= 0;
      m_out   <= '{0, 0, 0, 0};
    end else if (m_rem == 0) begin
      if (start) begin
        m_pend <= model_scan(line_own, line_opp);
        m_rem  <= LATENCY;
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) m_out <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy",       int'(busy),       int'(m_rem > 0));
      check("done",       int'(done),       int'(m_rem == 1));
      check("best_found", int'(best_found), int'(m_out.found));
      check("best_count", int'(best_count), m_out.count);
      check("best_pos",   int'(best_pos),   m_out.pos);
      check("threat_cnt", int'(threat_cnt), m_out.thr);
    end
  end

  // Called at #1 after a rising edge with the DUT idle; returns at #1 after the edge ending done.
  task automatic do_scan(input logic [LINE_LEN-1:0] own, input logic [LINE_LEN-1:0] opp,
                         input int f, input int c, input int p, input int t);
    int lat;
    line_own = own;
    line_opp = opp;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    line_own = ~own;
    line_opp = 19'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    check("latency",      lat,              LATENCY);
    check("lit_found",    int'(best_found), f);
    check("lit_count",    int'(best_count), c);
    check("lit_pos",      int'(best_pos),   p);
    check("lit_threat",   int'(threat_cnt), t);
    line_opp = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; line_own = '0; line_opp = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  int'(busy),       0);
    check("rst_done",  int'(done),       0);
    check("rst_found", int'(best_found), 0);
    check("rst_count", int'(best_count), 0);
    check("rst_pos",   int'(best_pos),   0);
    check("rst_thr",   int'(threat_cnt), 0);
    @(posedge clk); #1;

    // Back-to-back scans: each starts in the idle cycle right after the previous done.
    do_scan(19'h00000, 19'h00000, 1, 0, 0, 0);
    do_scan(19'h000F8, 19'h00000, 1, 5, 2, 4);
    do_scan(19'h000F8, 19'h00020, 1, 2, 6, 0);
    do_scan(~19'h20820, 19'h20820, 0, 0, 0, 0);
    do_scan(19'h003FF, 19'h0003F, 1, 4, 6, 1);

    // Start, then toggle start and inputs during the scan, then reset in scan cycle 7.
    line_own = 19'h7FFFF; line_opp = '0; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 6; i++) begin
      start    = i[0];
      line_own = 19'($urandom);
      line_opp = 19'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy",  int'(busy),       0);
    check("midrst_found", int'(best_found), 0);
    check("midrst_count", int'(best_count), 0);
    check("midrst_thr",   int'(threat_cnt), 0);
    begin
      int n_done;
      n_done = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) n_done++;
      end
      check("midrst_no_done", n_done, 0);
    end
    @(posedge clk); #1;
    do_scan(19'h7E000, 19'h00000, 1, 6, 13, 3);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
